// File: rtl/sram_arbiter_ctrl.sv
// SRAM controller for the SLC-3 memory subsystem: it arbitrates round-robin between
// the CPU and debug ports and runs each access as SETUP, WAIT_STATES x STROBE, then DONE.
module sram_arbiter_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [1:0]  dbg_be,
    input  logic [19:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ready,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_DBG = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;

    logic pick_dbg;
    logic access;
    logic drive;

    // On a tie the port that did not win last time is served.
    assign pick_dbg = dbg_req && (!cpu_req || (last_grant_q == PORT_CPU));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_DBG;
            we_q         <= 1'b0;
            be_q         <= 2'b00;
            addr_q       <= 20'h00000;
            wdata_q      <= 16'h0000;
            cpu_rdata_q  <= 16'h0000;
            dbg_rdata_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant_d = pick_dbg ? PORT_DBG : PORT_CPU;
                    we_d    = pick_dbg ? dbg_we    : cpu_we;
                    be_d    = pick_dbg ? dbg_be    : cpu_be;
                    addr_d  = pick_dbg ? dbg_addr  : cpu_addr;
                    wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (grant_q == PORT_DBG) dbg_rdata_d = Data;
                        else                     cpu_rdata_d = Data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so that an asynchronous reset
    // releases them at once; DONE leaves everything high for bus turnaround.
    assign access    = (state_q == SETUP) || (state_q == STROBE);
    assign drive     = access && we_q;
    assign CE        = ~access;
    assign UB        = ~(access && be_q[1]);
    assign LB        = ~(access && be_q[0]);
    assign OE        = ~(access && !we_q);
    assign WE        = ~((state_q == STROBE) && we_q);
    assign ADDR      = addr_q;
    assign Data      = drive ? wdata_q : 16'hzzzz;
    assign cpu_ready = (state_q == DONE) && (grant_q == PORT_CPU);
    assign dbg_ready = (state_q == DONE) && (grant_q == PORT_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: an SRAM model on the bus, a scoreboard of expected
// completions, and directed accesses that cover ties, byte lanes and reset mid-write.
module tb_sram_arbiter_ctrl;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]  cpu_be = 2'b00;
    logic [19:0] cpu_addr = 20'h0;
    logic [15:0] cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [1:0]  dbg_be = 2'b00;
    logic [19:0] dbg_addr = 20'h0;
    logic [15:0] dbg_wdata = 16'h0;
    logic [15:0] dbg_rdata;
    logic        dbg_ready;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    always #10 Clk = ~Clk;

    sram_arbiter_ctrl #(.WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
    );

    // Asynchronous SRAM model, 256 words deep (low address bits only).
    logic [15:0] sram [256];
    assign Data = (!CE && !OE && WE) ? sram[ADDR[7:0]] : 16'hzzzz;
    always @(posedge Clk) begin
        if (!CE && !WE) begin
            if (!UB) sram[ADDR[7:0]][15:8] <= Data[15:8];
            if (!LB) sram[ADDR[7:0]][7:0]  <= Data[7:0];
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_t;
    logic [15:0] ref_mem [256];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input bit port, input bit we, input logic [1:0] be,
                        input logic [19:0] addr, input logic [15:0] wdata);
        txn_t t;
        if (we) begin
            if (be[1]) ref_mem[addr[7:0]][15:8] = wdata[15:8];
            if (be[0]) ref_mem[addr[7:0]][7:0]  = wdata[7:0];
        end
        t.port = port;
        t.we   = we;
        t.addr = addr;
        t.data = ref_mem[addr[7:0]];
        sb.push_back(t);
    endtask

    task automatic drive_port(input bit port, input logic req, input bit we, input logic [1:0] be,
                              input logic [19:0] addr, input logic [15:0] wdata);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_be = be; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Scoreboard side: every ready pulse retires the oldest expected completion.
    always @(negedge Clk) begin
        if (cpu_ready || dbg_ready) begin
            check("ready_excl", {31'b0, cpu_ready & dbg_ready}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                mon_t = sb.pop_front();
                check("sb_port", {31'b0, dbg_ready}, {31'b0, mon_t.port});
                if (!mon_t.we)
                    check("sb_rdata", {16'h0, mon_t.port ? dbg_rdata : cpu_rdata}, {16'h0, mon_t.data});
                $display("txn port=%s we=%0d addr=%05h data=%04h",
                         mon_t.port ? "DBG" : "CPU", mon_t.we, mon_t.addr,
                         mon_t.port ? dbg_rdata : cpu_rdata);
            end
        end
    end

    task automatic do_access(input bit port, input bit we, input logic [1:0] be,
                             input logic [19:0] addr, input logic [15:0] wdata);
        int lat = 0, we_low = 0, oe_low = 0;
        logic ub_s = 1'b1, lb_s = 1'b1, got = 1'b0;
        logic [19:0] addr_s = 20'h0;
        @(negedge Clk);
        push(port, we, be, addr, wdata);
        drive_port(port, 1'b1, we, be, addr, wdata);
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge Clk);
            if (n == 1) addr_s = ADDR;
            if (!WE) begin we_low++; ub_s = UB; lb_s = LB; end
            if (!OE) oe_low++;
            if (port ? dbg_ready : cpu_ready) begin got = 1'b1; lat = n; end
        end
        drive_port(port, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
        check("latency", lat, WS + 2);
        check("addr", {12'h0, addr_s}, {12'h0, addr});
        check("we_low_cycles", we_low, we ? WS : 0);
        check("oe_low_cycles", oe_low, we ? 0 : WS + 1);
        if (we) begin
            check("ub_strobe", {31'b0, ub_s}, {31'b0, ~be[1]});
            check("lb_strobe", {31'b0, lb_s}, {31'b0, ~be[0]});
        end
    endtask

    initial begin
        int times [4];
        int k;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;

        repeat (2) @(negedge Clk);
        check("rst_ce", {31'b0, CE}, 1);
        check("rst_ub", {31'b0, UB}, 1);
        check("rst_lb", {31'b0, LB}, 1);
        check("rst_oe", {31'b0, OE}, 1);
        check("rst_we", {31'b0, WE}, 1);
        check("rst_addr", {12'h0, ADDR}, 0);
        check("rst_readies", {30'b0, cpu_ready, dbg_ready}, 0);
        check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        Reset = 1'b0;

        do_access(1'b0, 1'b1, 2'b11, 20'h00031, 16'hA0A0);
        check("mem_a0a0", {16'h0, sram[8'h31]}, 32'h0000A0A0);
        do_access(1'b0, 1'b0, 2'b11, 20'h00031, 16'h0);
        do_access(1'b1, 1'b1, 2'b01, 20'h00031, 16'h1234);
        check("mem_byte", {16'h0, sram[8'h31]}, 32'h0000A034);
        do_access(1'b1, 1'b0, 2'b11, 20'h00031, 16'h0);
        check("cpu_rdata_held", {16'h0, cpu_rdata}, 32'h0000A0A0);

        // Fresh reset so the first tie must go to the CPU.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        push(1'b0, 1'b0, 2'b11, 20'h00031, 16'h0);
        push(1'b1, 1'b1, 2'b11, 20'h00040, 16'hBEEF);
        push(1'b0, 1'b0, 2'b11, 20'h00031, 16'h0);
        push(1'b1, 1'b1, 2'b11, 20'h00040, 16'hBEEF);
        drive_port(1'b0, 1'b1, 1'b0, 2'b11, 20'h00031, 16'h0);
        drive_port(1'b1, 1'b1, 1'b1, 2'b11, 20'h00040, 16'hBEEF);
        k = 0;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(negedge Clk);
            if (cpu_ready || dbg_ready) begin times[k] = n; k++; end
        end
        drive_port(1'b0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
        drive_port(1'b1, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
        check("tie_count", k, 4);
        check("tie_first", times[0], WS + 2);
        for (int i = 1; i < 4; i++) check("tie_spacing", times[i] - times[i-1], WS + 3);
        check("mem_beef", {16'h0, sram[8'h40]}, 32'h0000BEEF);

        // Reset while the write strobe is low: everything releases without a clock.
        @(negedge Clk);
        drive_port(1'b0, 1'b1, 1'b1, 2'b11, 20'h00050, 16'h5555);
        repeat (2) @(negedge Clk);
        check("abort_we_pre", {31'b0, WE}, 0);
        Reset = 1'b1;
        #1;
        check("abort_we", {31'b0, WE}, 1);
        check("abort_ce", {31'b0, CE}, 1);
        check("abort_oe", {31'b0, OE}, 1);
        check("abort_bytes", {30'b0, UB, LB}, 32'd3);
        check("abort_addr", {12'h0, ADDR}, 0);
        check("abort_ready", {30'b0, cpu_ready, dbg_ready}, 0);
        drive_port(1'b0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
        repeat (2) begin
            @(negedge Clk);
            check("abort_no_ready", {31'b0, cpu_ready}, 0);
        end
        Reset = 1'b0;
        do_access(1'b0, 1'b1, 2'b11, 20'h00050, 16'h5555);
        do_access(1'b0, 1'b0, 2'b11, 20'h00050, 16'h0);

        repeat (3) @(negedge Clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
